axis_splitter: RTL and testbench

- Transmit-side counterpart of the four-channel receive summer.
- Takes one complex AXI-stream pair (real and imag, 8 × 16-bit samples per beat) and replicates it to the four channel outputs: 00, 01, 20 and 21, each with a real and an imag stream.
- Each output sample gets an optional arithmetic right-shift gain.
- Each output lane has its own one-entry register and its own tready, so the slowest enabled lane sets the backpressure.

---
 rtl/axis_splitter.sv | 226 ++++++++++++++++++++++
 tb/tb_axis_splitter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_splitter.sv
// axis_splitter: fans one complex AXI-stream pair (real + imag) out to four
// channel outputs (00, 01, 20, 21), each with a real and an imag lane.
// Every sample is arithmetically right-shifted by SHIFT on the way through.
// Each lane is a one-entry register with its own tready, so the slowest
// enabled lane throttles the shared input.
module axis_splitter #(
    parameter int SDATA_WIDTH   = 128,
    parameter int SSAMPLE_WIDTH = 16,
    parameter int SAMPLES       = SDATA_WIDTH / SSAMPLE_WIDTH,
    parameter int SHIFT         = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [3:0]               chan_enable,

    input  logic                     s_axis_real_tvalid,
    output logic                     s_axis_real_tready,
    input  logic [SDATA_WIDTH-1:0]   s_axis_real_tdata,
    input  logic                     s_axis_real_tlast,
    input  logic                     s_axis_imag_tvalid,
    output logic                     s_axis_imag_tready,
    input  logic [SDATA_WIDTH-1:0]   s_axis_imag_tdata,
    input  logic                     s_axis_imag_tlast,

    output logic [SDATA_WIDTH-1:0]   m00_axis_real_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m00_axis_real_s2mm_tkeep,
    output logic                     m00_axis_real_s2mm_tlast,
    output logic                     m00_axis_real_s2mm_tvalid,
    input  logic                     m00_axis_real_s2mm_tready,
    output logic [SDATA_WIDTH-1:0]   m00_axis_imag_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m00_axis_imag_s2mm_tkeep,
    output logic                     m00_axis_imag_s2mm_tlast,
    output logic                     m00_axis_imag_s2mm_tvalid,
    input  logic                     m00_axis_imag_s2mm_tready,

    output logic [SDATA_WIDTH-1:0]   m01_axis_real_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m01_axis_real_s2mm_tkeep,
    output logic                     m01_axis_real_s2mm_tlast,
    output logic                     m01_axis_real_s2mm_tvalid,
    input  logic                     m01_axis_real_s2mm_tready,
    output logic [SDATA_WIDTH-1:0]   m01_axis_imag_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m01_axis_imag_s2mm_tkeep,
    output logic                     m01_axis_imag_s2mm_tlast,
    output logic                     m01_axis_imag_s2mm_tvalid,
    input  logic                     m01_axis_imag_s2mm_tready,

    output logic [SDATA_WIDTH-1:0]   m20_axis_real_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m20_axis_real_s2mm_tkeep,
    output logic                     m20_axis_real_s2mm_tlast,
    output logic                     m20_axis_real_s2mm_tvalid,
    input  logic                     m20_axis_real_s2mm_tready,
    output logic [SDATA_WIDTH-1:0]   m20_axis_imag_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m20_axis_imag_s2mm_tkeep,
    output logic                     m20_axis_imag_s2mm_tlast,
    output logic                     m20_axis_imag_s2mm_tvalid,
    input  logic                     m20_axis_imag_s2mm_tready,

    output logic [SDATA_WIDTH-1:0]   m21_axis_real_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m21_axis_real_s2mm_tkeep,
    output logic                     m21_axis_real_s2mm_tlast,
    output logic                     m21_axis_real_s2mm_tvalid,
    input  logic                     m21_axis_real_s2mm_tready,
    output logic [SDATA_WIDTH-1:0]   m21_axis_imag_s2mm_tdata,
    output logic [SDATA_WIDTH/8-1:0] m21_axis_imag_s2mm_tkeep,
    output logic                     m21_axis_imag_s2mm_tlast,
    output logic                     m21_axis_imag_s2mm_tvalid,
    input  logic                     m21_axis_imag_s2mm_tready,

    output logic [CNT_WIDTH-1:0]     frame_count
);

    localparam int KEEP_WIDTH = SDATA_WIDTH / 8;
    localparam int LANES      = 8;

    // Lane numbering: lane = 2*channel + (imag ? 1 : 0), channels 00,01,20,21.
    logic [LANES-1:0]       laneValid_q, laneValid_d;
    logic [LANES-1:0]       laneLast_q,  laneLast_d;
    logic [SDATA_WIDTH-1:0] laneData_q [LANES];
    logic [SDATA_WIDTH-1:0] laneData_d [LANES];
    logic [KEEP_WIDTH-1:0]  laneKeep_q [LANES];
    logic [KEEP_WIDTH-1:0]  laneKeep_d [LANES];
    logic [3:0]             mask_q, mask_d;
    logic                   inFrame_q, inFrame_d;
    logic [CNT_WIDTH-1:0]   frameCount_q, frameCount_d;

    logic [LANES-1:0]       laneReady;
    logic [LANES-1:0]       laneFree;
    logic [LANES-1:0]       laneLoad;
    logic [3:0]             maskCur;
    logic                   rdy;
    logic                   accept;
    logic [SDATA_WIDTH-1:0] realScaled;
    logic [SDATA_WIDTH-1:0] imagScaled;

    // Per-sample arithmetic right shift; the result always fits the sample width.
    function automatic logic [SDATA_WIDTH-1:0] scaleBeat(input logic [SDATA_WIDTH-1:0] din);
        logic [SDATA_WIDTH-1:0] dout;
        dout = '0;
        for (int k = 0; k < SAMPLES; k++) begin
            dout[k*SSAMPLE_WIDTH +: SSAMPLE_WIDTH] =
                $signed(din[k*SSAMPLE_WIDTH +: SSAMPLE_WIDTH]) >>> SHIFT;
        end
        return dout;
    endfunction

    assign realScaled = scaleBeat(s_axis_real_tdata);
    assign imagScaled = scaleBeat(s_axis_imag_tdata);

    assign laneReady = {m21_axis_imag_s2mm_tready, m21_axis_real_s2mm_tready,
                        m20_axis_imag_s2mm_tready, m20_axis_real_s2mm_tready,
                        m01_axis_imag_s2mm_tready, m01_axis_real_s2mm_tready,
                        m00_axis_imag_s2mm_tready, m00_axis_real_s2mm_tready};

    // Handshake decision and next state for the frame tracker and every lane.
    // Mid-frame the latched mask rules; between frames chan_enable applies
    // directly so the first beat of a frame already uses the new mask.
    always_comb begin
        maskCur  = inFrame_q ? mask_q : chan_enable;
        laneFree = ~laneValid_q | laneReady;
        rdy      = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (maskCur[c] && !(laneFree[2*c] && laneFree[2*c+1])) begin
                rdy = 1'b0;
            end
        end
        accept = s_axis_real_tvalid & s_axis_imag_tvalid & rdy;

        mask_d       = mask_q;
        inFrame_d    = inFrame_q;
        frameCount_d = frameCount_q;
        if (accept) begin
            if (!inFrame_q) begin
                mask_d = chan_enable;
            end
            inFrame_d = !s_axis_real_tlast;
            if (s_axis_real_tlast) begin
                frameCount_d = frameCount_q + CNT_WIDTH'(1);
            end
        end

        laneLoad    = '0;
        laneValid_d = laneValid_q;
        laneLast_d  = laneLast_q;
        laneData_d  = laneData_q;
        laneKeep_d  = laneKeep_q;
        for (int l = 0; l < LANES; l++) begin
            laneLoad[l] = accept & maskCur[l/2];
            if (laneLoad[l]) begin
                laneValid_d[l] = 1'b1;
                laneKeep_d[l]  = '1;
                if (l % 2 == 1) begin
                    laneData_d[l] = imagScaled;
                    laneLast_d[l] = s_axis_imag_tlast;
                end else begin
                    laneData_d[l] = realScaled;
                    laneLast_d[l] = s_axis_real_tlast;
                end
            end else if (laneReady[l]) begin
                laneValid_d[l] = 1'b0;
            end
        end
    end

    // State registers; reset drops every pending beat and any open frame.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mask_q       <= '0;
            inFrame_q    <= 1'b0;
            frameCount_q <= '0;
            laneValid_q  <= '0;
            laneLast_q   <= '0;
            for (int l = 0; l < LANES; l++) begin
                laneData_q[l] <= '0;
                laneKeep_q[l] <= '0;
            end
        end else begin
            mask_q       <= mask_d;
            inFrame_q    <= inFrame_d;
            frameCount_q <= frameCount_d;
            laneValid_q  <= laneValid_d;
            laneLast_q   <= laneLast_d;
            laneData_q   <= laneData_d;
            laneKeep_q   <= laneKeep_d;
        end
    end

    // Both input streams share one ready so they always transfer together.
    assign s_axis_real_tready = resetn & accept;
    assign s_axis_imag_tready = resetn & accept;
    assign frame_count        = frameCount_q;

    assign m00_axis_real_s2mm_tdata  = laneData_q[0];
    assign m00_axis_real_s2mm_tkeep  = laneKeep_q[0];
    assign m00_axis_real_s2mm_tlast  = laneLast_q[0];
    assign m00_axis_real_s2mm_tvalid = laneValid_q[0];
    assign m00_axis_imag_s2mm_tdata  = laneData_q[1];
    assign m00_axis_imag_s2mm_tkeep  = laneKeep_q[1];
    assign m00_axis_imag_s2mm_tlast  = laneLast_q[1];
    assign m00_axis_imag_s2mm_tvalid = laneValid_q[1];
    assign m01_axis_real_s2mm_tdata  = laneData_q[2];
    assign m01_axis_real_s2mm_tkeep  = laneKeep_q[2];
    assign m01_axis_real_s2mm_tlast  = laneLast_q[2];
    assign m01_axis_real_s2mm_tvalid = laneValid_q[2];
    assign m01_axis_imag_s2mm_tdata  = laneData_q[3];
    assign m01_axis_imag_s2mm_tkeep  = laneKeep_q[3];
    assign m01_axis_imag_s2mm_tlast  = laneLast_q[3];
    assign m01_axis_imag_s2mm_tvalid = laneValid_q[3];
    assign m20_axis_real_s2mm_tdata  = laneData_q[4];
    assign m20_axis_real_s2mm_tkeep  = laneKeep_q[4];
    assign m20_axis_real_s2mm_tlast  = laneLast_q[4];
    assign m20_axis_real_s2mm_tvalid = laneValid_q[4];
    assign m20_axis_imag_s2mm_tdata  = laneData_q[5];
    assign m20_axis_imag_s2mm_tkeep  = laneKeep_q[5];
    assign m20_axis_imag_s2mm_tlast  = laneLast_q[5];
    assign m20_axis_imag_s2mm_tvalid = laneValid_q[5];
    assign m21_axis_real_s2mm_tdata  = laneData_q[6];
    assign m21_axis_real_s2mm_tkeep  = laneKeep_q[6];
    assign m21_axis_real_s2mm_tlast  = laneLast_q[6];
    assign m21_axis_real_s2mm_tvalid = laneValid_q[6];
    assign m21_axis_imag_s2mm_tdata  = laneData_q[7];
    assign m21_axis_imag_s2mm_tkeep  = laneKeep_q[7];
    assign m21_axis_imag_s2mm_tlast  = laneLast_q[7];
    assign m21_axis_imag_s2mm_tvalid = laneValid_q[7];

endmodule

// File: tb/tb_axis_splitter.sv
// Testbench for axis_splitter: two instances (SHIFT=0 and SHIFT=2) share the
// same stimulus; a scoreboard of per-lane queues holds the expected beats.
module tb_axis_splitter;

    typedef struct {
        logic [127:0] exp0;
        logic [127:0] exp2;
        logic         last;
    } beat_t;

    logic         clock;
    logic         resetn;
    logic [3:0]   chanEnable;
    logic         rValid, iValid, rLast, iLast;
    logic [127:0] rData, iData;
    logic [7:0]   mReady;
    wire          rReady0, iReady0, rReady1, iReady1;
    wire  [127:0] outData0 [8];
    wire  [127:0] outData1 [8];
    wire  [15:0]  outKeep0 [8];
    wire  [15:0]  outKeep1 [8];
    wire  [7:0]   outValid0, outLast0, outValid1, outLast1;
    wire  [31:0]  frameCount0, frameCount1;

    beat_t        expQ [8][$];
    int           nChecks = 0;
    int           nFail = 0;
    int           cycleCount = 0;
    int           lastWait = 0;
    int           acceptCycle = 0;
    int           prevAccept = 0;

    axis_splitter #(.SHIFT(0)) dut0 (
        .clock(clock), .resetn(resetn), .chan_enable(chanEnable),
        .s_axis_real_tvalid(rValid), .s_axis_real_tready(rReady0), .s_axis_real_tdata(rData), .s_axis_real_tlast(rLast),
        .s_axis_imag_tvalid(iValid), .s_axis_imag_tready(iReady0), .s_axis_imag_tdata(iData), .s_axis_imag_tlast(iLast),
        .m00_axis_real_s2mm_tdata(outData0[0]), .m00_axis_real_s2mm_tkeep(outKeep0[0]), .m00_axis_real_s2mm_tlast(outLast0[0]), .m00_axis_real_s2mm_tvalid(outValid0[0]), .m00_axis_real_s2mm_tready(mReady[0]),
        .m00_axis_imag_s2mm_tdata(outData0[1]), .m00_axis_imag_s2mm_tkeep(outKeep0[1]), .m00_axis_imag_s2mm_tlast(outLast0[1]), .m00_axis_imag_s2mm_tvalid(outValid0[1]), .m00_axis_imag_s2mm_tready(mReady[1]),
        .m01_axis_real_s2mm_tdata(outData0[2]), .m01_axis_real_s2mm_tkeep(outKeep0[2]), .m01_axis_real_s2mm_tlast(outLast0[2]), .m01_axis_real_s2mm_tvalid(outValid0[2]), .m01_axis_real_s2mm_tready(mReady[2]),
        .m01_axis_imag_s2mm_tdata(outData0[3]), .m01_axis_imag_s2mm_tkeep(outKeep0[3]), .m01_axis_imag_s2mm_tlast(outLast0[3]), .m01_axis_imag_s2mm_tvalid(outValid0[3]), .m01_axis_imag_s2mm_tready(mReady[3]),
        .m20_axis_real_s2mm_tdata(outData0[4]), .m20_axis_real_s2mm_tkeep(outKeep0[4]), .m20_axis_real_s2mm_tlast(outLast0[4]), .m20_axis_real_s2mm_tvalid(outValid0[4]), .m20_axis_real_s2mm_tready(mReady[4]),
        .m20_axis_imag_s2mm_tdata(outData0[5]), .m20_axis_imag_s2mm_tkeep(outKeep0[5]), .m20_axis_imag_s2mm_tlast(outLast0[5]), .m20_axis_imag_s2mm_tvalid(outValid0[5]), .m20_axis_imag_s2mm_tready(mReady[5]),
        .m21_axis_real_s2mm_tdata(outData0[6]), .m21_axis_real_s2mm_tkeep(outKeep0[6]), .m21_axis_real_s2mm_tlast(outLast0[6]), .m21_axis_real_s2mm_tvalid(outValid0[6]), .m21_axis_real_s2mm_tready(mReady[6]),
        .m21_axis_imag_s2mm_tdata(outData0[7]), .m21_axis_imag_s2mm_tkeep(outKeep0[7]), .m21_axis_imag_s2mm_tlast(outLast0[7]), .m21_axis_imag_s2mm_tvalid(outValid0[7]), .m21_axis_imag_s2mm_tready(mReady[7]),
        .frame_count(frameCount0)
    );

    axis_splitter #(.SHIFT(2)) dut1 (
        .clock(clock), .resetn(resetn), .chan_enable(chanEnable),
        .s_axis_real_tvalid(rValid), .s_axis_real_tready(rReady1), .s_axis_real_tdata(rData), .s_axis_real_tlast(rLast),
        .s_axis_imag_tvalid(iValid), .s_axis_imag_tready(iReady1), .s_axis_imag_tdata(iData), .s_axis_imag_tlast(iLast),
        .m00_axis_real_s2mm_tdata(outData1[0]), .m00_axis_real_s2mm_tkeep(outKeep1[0]), .m00_axis_real_s2mm_tlast(outLast1[0]), .m00_axis_real_s2mm_tvalid(outValid1[0]), .m00_axis_real_s2mm_tready(mReady[0]),
        .m00_axis_imag_s2mm_tdata(outData1[1]), .m00_axis_imag_s2mm_tkeep(outKeep1[1]), .m00_axis_imag_s2mm_tlast(outLast1[1]), .m00_axis_imag_s2mm_tvalid(outValid1[1]), .m00_axis_imag_s2mm_tready(mReady[1]),
        .m01_axis_real_s2mm_tdata(outData1[2]), .m01_axis_real_s2mm_tkeep(outKeep1[2]), .m01_axis_real_s2mm_tlast(outLast1[2]), .m01_axis_real_s2mm_tvalid(outValid1[2]), .m01_axis_real_s2mm_tready(mReady[2]),
        .m01_axis_imag_s2mm_tdata(outData1[3]), .m01_axis_imag_s2mm_tkeep(outKeep1[3]), .m01_axis_imag_s2mm_tlast(outLast1[3]), .m01_axis_imag_s2mm_tvalid(outValid1[3]), .m01_axis_imag_s2mm_tready(mReady[3]),
        .m20_axis_real_s2mm_tdata(outData1[4]), .m20_axis_real_s2mm_tkeep(outKeep1[4]), .m20_axis_real_s2mm_tlast(outLast1[4]), .m20_axis_real_s2mm_tvalid(outValid1[4]), .m20_axis_real_s2mm_tready(mReady[4]),
        .m20_axis_imag_s2mm_tdata(outData1[5]), .m20_axis_imag_s2mm_tkeep(outKeep1[5]), .m20_axis_imag_s2mm_tlast(outLast1[5]), .m20_axis_imag_s2mm_tvalid(outValid1[5]), .m20_axis_imag_s2mm_tready(mReady[5]),
        .m21_axis_real_s2mm_tdata(outData1[6]), .m21_axis_real_s2mm_tkeep(outKeep1[6]), .m21_axis_real_s2mm_tlast(outLast1[6]), .m21_axis_real_s2mm_tvalid(outValid1[6]), .m21_axis_real_s2mm_tready(mReady[6]),
        .m21_axis_imag_s2mm_tdata(outData1[7]), .m21_axis_imag_s2mm_tkeep(outKeep1[7]), .m21_axis_imag_s2mm_tlast(outLast1[7]), .m21_axis_imag_s2mm_tvalid(outValid1[7]), .m21_axis_imag_s2mm_tready(mReady[7]),
        .frame_count(frameCount1)
    );

    // Free-running clock and a cycle counter used for throughput checks.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Hard time limit so the bench can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference scaling: floor division of each signed sample by 2^sh.
    function automatic logic [127:0] shiftRef(input logic [127:0] d, input int sh);
        logic [127:0] res;
        int s, q, div;
        div = 1 << sh;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            s = int'($signed(d[k*16 +: 16]));
            if (s >= 0) q = s / div;
            else        q = -((-s + div - 1) / div);
            res[k*16 +: 16] = q[15:0];
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Present one beat on both streams, wait (bounded) for the handshake,
    // and queue the expected output on every lane enabled by expMask.
    task automatic applyStimulus(input logic [127:0] r, input logic [127:0] im,
                                 input logic lastBit, input logic [3:0] expMask);
        int waitCycles;
        bit timedOut;
        waitCycles = 0;
        timedOut = 1'b0;
        rData = r; iData = im; rLast = lastBit; iLast = lastBit;
        rValid = 1'b1; iValid = 1'b1;
        #1;
        while (!rReady0) begin
            if (waitCycles >= 50) begin
                timedOut = 1'b1;
                break;
            end
            @(posedge clock);
            #3;
            waitCycles++;
        end
        lastWait = waitCycles;
        if (timedOut) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL handshake: got no tready after %0d cycles required tready", waitCycles);
            rValid = 1'b0; iValid = 1'b0;
            #1;
        end else begin
            for (int l = 0; l < 8; l++) begin
                if (expMask[l/2]) begin
                    beat_t e;
                    e.exp0 = (l % 2 == 1) ? im : r;
                    e.exp2 = shiftRef((l % 2 == 1) ? im : r, 2);
                    e.last = lastBit;
                    expQ[l].push_back(e);
                end
            end
            prevAccept  = acceptCycle;
            acceptCycle = cycleCount;
            tick();
            rValid = 1'b0; iValid = 1'b0;
        end
    endtask

    // Monitor: every lane transfer is popped from that lane's queue and compared.
    always @(negedge clock) begin
        if (resetn === 1'b1) begin
            for (int l = 0; l < 8; l++) begin
                if (outValid0[l] === 1'b1 && mReady[l] === 1'b1) begin
                    if (expQ[l].size() == 0) begin
                        nChecks++;
                        nFail++;
                        $display("[TB] FAIL lane%0d_unexpected: got tvalid=1 required no beat", l);
                    end else begin
                        beat_t e;
                        e = expQ[l].pop_front();
                        checkOutput($sformatf("lane%0d_data", l), outData0[l], e.exp0);
                        checkOutput($sformatf("lane%0d_data_shift2", l), outData1[l], e.exp2);
                        checkOutput($sformatf("lane%0d_keep", l), 128'(outKeep0[l]), 128'h0000_0000_0000_0000_0000_0000_0000_FFFF);
                        checkOutput($sformatf("lane%0d_last", l), 128'(outLast0[l]), 128'(e.last));
                    end
                end
            end
        end
    end

    initial begin
        logic [127:0] ramp, minus1, shR, shI;
        logic [127:0] stallR1, stallI1, holdVal;
        int qLeft;

        ramp    = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        minus1  = {8{16'hFFFF}};
        shR     = 128'h0000_0000_0000_0000_0000_0000_0007_8000;
        shI     = 128'h0000_0000_0000_0000_0000_0000_0000_FFFD;
        stallR1 = {8{16'h1111}};
        stallI1 = {8{16'h2222}};

        resetn = 1'b0; chanEnable = 4'b0000; mReady = 8'hFF;
        rValid = 1'b1; iValid = 1'b1; rLast = 1'b0; iLast = 1'b0;
        rData = '0; iData = '0;
        repeat (3) tick();
        checkOutput("reset_tvalid", 128'(outValid0), 128'd0);
        checkOutput("reset_tready", 128'(rReady0), 128'd0);
        checkOutput("reset_frame_count", 128'(frameCount0), 128'd0);
        checkOutput("reset_tkeep", 128'(outKeep0[0]), 128'd0);
        checkOutput("reset_tdata", outData0[3], 128'd0);
        rValid = 1'b0; iValid = 1'b0;
        resetn = 1'b1;
        tick();

        // Single beat replicated to all 8 lanes, one cycle latency.
        chanEnable = 4'b1111;
        applyStimulus(ramp, minus1, 1'b0, 4'b1111);
        checkOutput("latency_all_valid", 128'(outValid0), 128'hFF);
        checkOutput("frame_count_mid", 128'(frameCount0), 128'd0);

        // Shift-by-2 corner values: 0x8000->0xE000, 0x0007->0x0001, 0xFFFD->0xFFFF.
        applyStimulus(shR, shI, 1'b1, 4'b1111);
        checkOutput("shift2_neg_full", 128'(outData1[0][15:0]), 128'hE000);
        checkOutput("shift2_pos", 128'(outData1[0][31:16]), 128'h0001);
        checkOutput("shift2_imag", 128'(outData1[1][15:0]), 128'hFFFF);
        checkOutput("frame_count_1", 128'(frameCount0), 128'd1);
        tick();

        // Backpressure from m20 imag alone stalls the whole input.
        mReady[5] = 1'b0;
        applyStimulus(stallR1, stallI1, 1'b0, 4'b1111);
        fork
            applyStimulus({8{16'h3333}}, {8{16'h4444}}, 1'b0, 4'b1111);
            begin
                #1;
                checkOutput("stall_tready_c1", 128'(rReady0), 128'd0);
                tick();
                #1;
                checkOutput("stall_tready_c2", 128'(rReady0), 128'd0);
                checkOutput("stall_lane5_valid", 128'(outValid0[5]), 128'd1);
                holdVal = outData0[5];
                checkOutput("stall_lane5_hold1", holdVal, stallI1);
                tick();
                holdVal = outData0[5];
                checkOutput("stall_lane5_hold2", holdVal, stallI1);
                mReady[5] = 1'b1;
            end
        join
        applyStimulus({8{16'h5555}}, {8{16'h6666}}, 1'b1, 4'b1111);
        checkOutput("resume_throughput", 128'(acceptCycle - prevAccept), 128'd1);
        checkOutput("frame_count_2", 128'(frameCount0), 128'd2);

        // Mask latched on the first beat; a mid-frame change is ignored.
        chanEnable = 4'b0101;
        applyStimulus({8{16'h0101}}, {8{16'h0202}}, 1'b0, 4'b0101);
        chanEnable = 4'b1111;
        applyStimulus({8{16'h0303}}, {8{16'h0404}}, 1'b0, 4'b0101);
        checkOutput("mask_lanes_valid", 128'(outValid0), 128'h33);
        applyStimulus({8{16'h0505}}, {8{16'h0606}}, 1'b0, 4'b0101);
        applyStimulus({8{16'h0707}}, {8{16'h0808}}, 1'b1, 4'b0101);
        checkOutput("frame_count_3", 128'(frameCount0), 128'd3);
        applyStimulus({8{16'h7F00}}, {8{16'h80FF}}, 1'b0, 4'b1111);
        applyStimulus({8{16'hC001}}, {8{16'h3FFE}}, 1'b1, 4'b1111);
        checkOutput("frame_count_4", 128'(frameCount0), 128'd4);

        // Empty mask: beats accepted every cycle and dropped; frames still counted.
        chanEnable = 4'b0000;
        for (int b = 0; b < 10; b++) begin
            applyStimulus(128'(b), 128'(b + 100), (b == 4 || b == 9), 4'b0000);
            checkOutput($sformatf("mask0_no_wait_%0d", b), 128'(lastWait), 128'd0);
        end
        tick();
        checkOutput("mask0_no_valid", 128'(outValid0), 128'd0);
        checkOutput("frame_count_6", 128'(frameCount0), 128'd6);

        // Reset in the middle of a stalled frame.
        chanEnable = 4'b1111;
        mReady = 8'h00;
        applyStimulus({8{16'hAAAA}}, {8{16'hBBBB}}, 1'b0, 4'b1111);
        rData = {8{16'hCCCC}}; iData = {8{16'hDDDD}};
        rValid = 1'b1; iValid = 1'b1;
        #1;
        checkOutput("pre_reset_stalled", 128'(rReady0), 128'd0);
        resetn = 1'b0;
        tick();
        checkOutput("midreset_tvalid", 128'(outValid0), 128'd0);
        checkOutput("midreset_tready", 128'(rReady0), 128'd0);
        checkOutput("midreset_frame_count", 128'(frameCount0), 128'd0);
        for (int l = 0; l < 8; l++) expQ[l].delete();
        rValid = 1'b0; iValid = 1'b0;
        resetn = 1'b1;
        mReady = 8'hFF;
        tick();

        // First beat after reset latches chan_enable afresh.
        chanEnable = 4'b0011;
        applyStimulus({8{16'h1234}}, {8{16'hFEDC}}, 1'b0, 4'b0011);
        chanEnable = 4'b1111;
        applyStimulus({8{16'h8001}}, {8{16'h0FF0}}, 1'b1, 4'b0011);
        checkOutput("relatch_valid", 128'(outValid0), 128'h0F);
        checkOutput("frame_count_after_reset", 128'(frameCount0), 128'd1);
        repeat (3) tick();
        checkOutput("frame_count_shift2_inst", 128'(frameCount1), 128'd1);

        qLeft = 0;
        for (int l = 0; l < 8; l++) qLeft += expQ[l].size();
        checkOutput("scoreboard_drained", 128'(qLeft), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
